// File: rtl/nibble_serial_add_seq.sv
// nibble_serial_add_seq
// Drives one external combinational 4-bit adder slice to build a WIDTH-bit add.
// The slice is used once per cycle, least significant nibble first. The carry
// out of each nibble is stored in a register and fed back as the next carry-in.
// Operands come in on a valid/ready handshake. The WIDTH+1-bit result leaves on
// another valid/ready handshake.
// WIDTH must be a multiple of 4 and at least 4.
module nibble_serial_add_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_ci,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_ci,
    input  logic [4:0]       add_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum
);

    localparam int NIB = WIDTH / 4;
    // A one-nibble build still needs a 1-bit index so the declarations stay legal.
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(NIB - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH:0]   sum_q;
    logic             carry_q;
    logic [IW-1:0]    idx_q;
    logic [IW+1:0]    bit_off_s;

    // The bit offset of the current nibble is idx*4. It is built by
    // concatenation so that no multiply is needed.
    assign bit_off_s = {idx_q, 2'b00};

    // Both handshake flags come only from the state register. They have no
    // combinational path from the inputs.
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_sum   = sum_q;

    // Present the current nibble pair and the chained carry to the slice
    // during RUN. Hold the slice inputs at zero in every other state.
    always_comb begin
        add_a  = 4'd0;
        add_b  = 4'd0;
        add_ci = 1'b0;
        if (state_q == S_RUN) begin
            add_a  = a_q[bit_off_s +: 4];
            add_b  = b_q[bit_off_s +: 4];
            add_ci = carry_q;
        end else begin
            add_a  = 4'd0;
            add_b  = 4'd0;
            add_ci = 1'b0;
        end
    end

    // Sequencer: accept operands, capture one slice result per cycle, then
    // hold the finished sum until the consumer takes it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q     <= in_a;
                        b_q     <= in_b;
                        carry_q <= in_ci;
                        idx_q   <= '0;
                        state_q <= S_RUN;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    sum_q[bit_off_s +: 4] <= add_sum[3:0];
                    carry_q               <= add_sum[4];
                    if (idx_q == IDX_LAST) begin
                        // The carry out of the top nibble becomes the extra result bit.
                        sum_q[WIDTH] <= add_sum[4];
                        idx_q        <= '0;
                        state_q      <= S_DONE;
                    end else begin
                        idx_q   <= idx_q + IW'(1);
                        state_q <= S_RUN;
                    end
                end
                S_DONE: begin
                    // A new operand offered now is not taken. It waits for IDLE.
                    if (out_ready) begin
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
